sample_fetch: RTL and testbench

Downstream of the address incrementer, between it and the audio codec output path. Paces playback at the sample rate, reads the sample at the incrementer's current address from sample memory via a req/ack handshake, and presents one signed sample per sample period. Pulses `increment` back to the incrementer after each successful fetch, and stops at the note's end address.

---
 rtl/synth_pkg.sv | 16 +
 rtl/sample_fetch_if.sv | 26 ++
 rtl/sample_tick_gen.sv | 28 ++
 rtl/sample_fetch.sv | 129 ++++++++++++
 tb/tb_sample_fetch.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and widths for the synth sample path (incrementer, fetch, mixer, codec).
package synth_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    UPDATE
  } fetch_state_t;

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_fetch_if.sv
// Sample-memory read port: req/ack handshake, address held while Mem_Req is high.
interface sample_fetch_if #(
  parameter int ADDR_W = synth_pkg::ADDR_W,
  parameter int DATA_W = synth_pkg::DATA_W
);

  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output Mem_Req,
    output Mem_Addr,
    input  Mem_Ack,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Req,
    input  Mem_Addr,
    output Mem_Ack,
    output Mem_Data
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running 0..CLK_DIV-1 counter; tick is high for the single cycle the count sits at CLK_DIV-1.
module sample_tick_gen #(
  parameter int CLK_DIV = 1042
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/sample_fetch.sv
// Paces playback: one memory fetch per sample period, one Sample_Valid pulse per period, silence at note end.
module sample_fetch #(
  parameter int ADDR_W  = synth_pkg::ADDR_W,
  parameter int DATA_W  = synth_pkg::DATA_W,
  parameter int CLK_DIV = 1042
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic        [ADDR_W-1:0] Address,
  input  logic        [ADDR_W-1:0] End_Address,
  input  logic                     note_start,
  input  logic                     invalid_note,
  output logic                     increment,
  sample_fetch_if.master           mem,
  output logic signed [DATA_W-1:0] Sample,
  output logic                     Sample_Valid,
  output logic                     note_done,
  output logic                     Overrun
);

  import synth_pkg::*;

  fetch_state_t state, next_state;

  logic              tick;
  logic              fetching;
  logic              silence;
  logic              drop_data;
  logic              discard_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic                     discard_d;
  logic [ADDR_W-1:0]        mem_addr_d;
  logic signed [DATA_W-1:0] sample_d;
  logic                     valid_d;
  logic                     inc_d;
  logic                     done_d;
  logic                     overrun_d;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  assign fetching = (state == REQ) || (state == WAIT_ACK);
  // A note_start coinciding with the tick must override a stale note_done.
  assign silence   = invalid_note || (note_done && !note_start);
  assign drop_data = discard_q || note_start;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:          if (tick && !silence) next_state = REQ;
      REQ, WAIT_ACK: next_state = mem.Mem_Ack ? UPDATE : WAIT_ACK;
      UPDATE:        next_state = IDLE;
      default:       next_state = IDLE;
    endcase
  end

  // Next values for the registered outputs; they land in the UPDATE cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    discard_d  = discard_q;
    mem_addr_d = mem_addr_q;
    sample_d   = Sample;
    valid_d    = 1'b0;
    inc_d      = 1'b0;
    done_d     = note_start ? 1'b0 : note_done;
    overrun_d  = Overrun || (tick && (state != IDLE));

    unique case (state)
      IDLE: begin
        if (tick && silence) begin
          sample_d = '0;
          valid_d  = 1'b1;
        end else if (tick) begin
          mem_addr_d = Address;
        end
      end
      REQ, WAIT_ACK: begin
        if (note_start) discard_d = 1'b1;
        if (mem.Mem_Ack && !drop_data) begin
          sample_d = mem.Mem_Data;
          valid_d  = 1'b1;
          if (mem_addr_q < End_Address) inc_d  = 1'b1;
          else                          done_d = 1'b1;
        end
      end
      UPDATE:  discard_d = 1'b0;
      default: discard_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      discard_q    <= 1'b0;
      mem_addr_q   <= '0;
      Sample       <= '0;
      Sample_Valid <= 1'b0;
      increment    <= 1'b0;
      note_done    <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      discard_q    <= discard_d;
      mem_addr_q   <= mem_addr_d;
      Sample       <= sample_d;
      Sample_Valid <= valid_d;
      increment    <= inc_d;
      note_done    <= done_d;
      Overrun      <= overrun_d;
    end
  end

  // Request is a pure function of state so an async reset drops it at once.
  assign mem.Mem_Req  = fetching;
  assign mem.Mem_Addr = mem_addr_q;

endmodule

// File: tb/tb_sample_fetch.sv
// Self-checking bench for sample_fetch: period-level reference model, latency-programmable memory, incrementer stub.
module tb_sample_fetch;
  import synth_pkg::*;

  localparam int CLK_DIV = 8;
  localparam int AW      = ADDR_W;
  localparam int DW      = DATA_W;

  logic          Clk          = 1'b0;
  logic          Reset_n      = 1'b0;
  logic [AW-1:0] Address      = '0;
  logic [AW-1:0] End_Address  = '0;
  logic          note_start   = 1'b0;
  logic          invalid_note = 1'b0;
  logic          increment;
  sample_t       Sample;
  logic          Sample_Valid;
  logic          note_done;
  logic          Overrun;

  sample_fetch_if mem ();

  sample_fetch #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Address      (Address),
    .End_Address  (End_Address),
    .note_start   (note_start),
    .invalid_note (invalid_note),
    .increment    (increment),
    .mem          (mem),
    .Sample       (Sample),
    .Sample_Valid (Sample_Valid),
    .note_done    (note_done),
    .Overrun      (Overrun)
  );

  always #5 Clk = ~Clk;

  // Cycles since reset release; a fetch request shows up after every edge where cyc % CLK_DIV == 0.
  int cyc;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Memory: ack arrives 'lat' cycles after the request rises (lat = 0 acks in the request cycle).
  int          lat     = 0;
  int          req_age = 0;
  logic [15:0] seed16  = 16'h0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a, input logic [15:0] s);
    if (a == 20'h00100) return 16'h1234;
    return a[15:0] ^ {a[19:16], 12'h5A5} ^ s;
  endfunction

  assign mem.Mem_Ack  = mem.Mem_Req && (req_age == lat);
  assign mem.Mem_Data = mem_fn(mem.Mem_Addr, seed16);

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         req_age <= 0;
    else if (mem.Mem_Req && !mem.Mem_Ack) req_age <= req_age + 1;
    else                                  req_age <= 0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the note being played, one step per sample period.
  logic [AW-1:0] m_addr, m_end;
  logic          m_done, m_inv, m_ovr;
  logic [DW-1:0] m_sample;

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_increment"}, increment, 0);
    check({pfx, "_mem_req"}, mem.Mem_Req, 0);
    check({pfx, "_mem_addr"}, mem.Mem_Addr, 0);
    check({pfx, "_sample"}, $unsigned(Sample), 0);
    check({pfx, "_valid"}, Sample_Valid, 0);
    check({pfx, "_note_done"}, note_done, 0);
    check({pfx, "_overrun"}, Overrun, 0);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 100 && cyc != target; i++) @(negedge Clk);
    check("align", cyc, target);
  endtask

  task automatic apply_note(input logic [AW-1:0] a, input logic [AW-1:0] e);
    m_done = 1'b0;
    m_addr = a;
    m_end  = e;
  endtask

  // Runs one sample period starting just before its tick edge; ns_off >= 0 pulses note_start
  // at that offset with a new note (a, e); next_inv is applied for the following tick.
  task automatic run_period(input int lat_i, input int ns_off, input logic [AW-1:0] ns_addr,
                            input logic [AW-1:0] ns_end, input logic next_inv);
    bit            fetch, discard, exp_inc;
    int            req_first, n_req, n_valid, valid_off, n_inc, inc_off, addr_bad;
    logic [DW-1:0] vsample, exp_s;
    logic [AW-1:0] req_addr;
    fetch     = !(m_inv || m_done);
    discard   = fetch && (ns_off >= 0) && (ns_off <= lat_i);
    req_first = -1; n_req = 0; n_valid = 0; valid_off = -1; n_inc = 0; inc_off = -1; addr_bad = 0;
    vsample   = '0; req_addr = '0;
    lat       = lat_i;
    for (int off = 0; off < CLK_DIV; off++) begin
      @(negedge Clk);
      note_start = 1'b0;
      if (mem.Mem_Req) begin
        if (n_req == 0) begin
          req_first = off;
          req_addr  = mem.Mem_Addr;
        end else if (mem.Mem_Addr !== req_addr) begin
          addr_bad++;
        end
        n_req++;
      end
      if (Sample_Valid) begin
        n_valid++;
        valid_off = off;
        vsample   = $unsigned(Sample);
      end
      if (increment) begin
        n_inc++;
        inc_off = off;
        Address = Address + 20'd1;
      end
      if (ns_off >= 0 && off == ns_off + 1) check("ns_clears_done", note_done, 0);
      if (off == ns_off) begin
        note_start  = 1'b1;
        Address     = ns_addr;
        End_Address = ns_end;
      end
      if (off == CLK_DIV - 1) invalid_note = next_inv;
    end

    if (fetch) begin
      check("req_after_tick", req_first, 0);
      check("req_addr", req_addr, m_addr);
      check("req_len", n_req, lat_i + 1);
      check("addr_held", addr_bad, 0);
      if (discard) begin
        check("discard_valid", n_valid, 0);
        check("discard_inc", n_inc, 0);
      end else begin
        exp_s   = mem_fn(m_addr, seed16);
        exp_inc = (m_addr < m_end);
        check("valid_count", n_valid, 1);
        check("valid_latency", valid_off, lat_i + 1);
        check("sample", vsample, exp_s);
        check("inc_count", n_inc, exp_inc ? 1 : 0);
        if (exp_inc) check("inc_latency", inc_off, lat_i + 1);
        m_sample = exp_s;
        if (exp_inc) m_addr = m_addr + 20'd1;
        else         m_done = 1'b1;
      end
    end else begin
      check("silence_req", n_req, 0);
      check("silence_valid", n_valid, 1);
      check("silence_latency", valid_off, 0);
      check("silence_sample", vsample, 0);
      check("silence_inc", n_inc, 0);
      m_sample = '0;
    end

    if (ns_off >= 0 && ns_off < CLK_DIV - 1) apply_note(ns_addr, ns_end);
    check("sample_hold", $unsigned(Sample), m_sample);
    check("note_done", note_done, m_done);
    check("overrun", Overrun, m_ovr);
    if (ns_off == CLK_DIV - 1) apply_note(ns_addr, ns_end);
    m_inv = next_inv;
  endtask

  // Latency of 7 makes every second tick land on an outstanding fetch.
  task automatic run_overrun(input int n_pairs);
    int   n_rise = 0, n_valid = 0, n_inc = 0;
    logic prev_req = 1'b0;
    lat = 7;
    for (int p = 0; p < 2 * CLK_DIV * n_pairs; p++) begin
      @(negedge Clk);
      if (mem.Mem_Req && !prev_req) n_rise++;
      prev_req = mem.Mem_Req;
      if (Sample_Valid) begin
        n_valid++;
        check("ovr_sample", $unsigned(Sample), mem_fn(m_addr, seed16));
        m_sample = mem_fn(m_addr, seed16);
        m_addr   = m_addr + 20'd1;
      end
      if (increment) begin
        n_inc++;
        Address = Address + 20'd1;
      end
      if (p == CLK_DIV - 1) check("ovr_before", Overrun, m_ovr);
      if (p == CLK_DIV)     check("ovr_set", Overrun, 1);
    end
    m_ovr = 1'b1;
    check("ovr_req_count", n_rise, n_pairs);
    check("ovr_valid_count", n_valid, n_pairs);
    check("ovr_inc_count", n_inc, n_pairs);
    check("ovr_sticky", Overrun, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    seed16      = 16'($urandom);
    Address     = 20'h00100;
    End_Address = 20'h001FF;
    apply_note(20'h00100, 20'h001FF);
    m_inv = 1'b0; m_ovr = 1'b0; m_sample = '0;

    repeat (3) @(negedge Clk);
    check_reset_vals("rst");
    Reset_n = 1'b1;
    wait_cyc(CLK_DIV - 1);

    // Normal playback, zero-wait memory: first sample is 0x1234.
    repeat (3) run_period(0, -1, '0, '0, 1'b0);

    // Single-sample note: end reached, then silence.
    Address = 20'h00200; End_Address = 20'h00200;
    apply_note(20'h00200, 20'h00200);
    repeat (3) run_period(0, -1, '0, '0, 1'b0);

    // note_start while done; then an address above the end behaves as the end.
    run_period(0, 3, 20'h00300, 20'h00300, 1'b0);
    run_period(0, CLK_DIV - 1, 20'h003F0, 20'h00300, 1'b0);
    run_period(0, -1, '0, '0, 1'b0);
    run_period(0, CLK_DIV - 1, 20'h00300, 20'h003FF, 1'b0);

    // note_start during WAIT_ACK discards the fetch; next tick fetches the new note.
    run_period(3, 1, 20'h00340, 20'h003FF, 1'b0);
    run_period(3, -1, '0, '0, 1'b0);

    // Overrun with latency 7, then it stays set.
    run_overrun(2);
    run_period(0, -1, '0, '0, 1'b0);

    // invalid_note for three ticks gives three silent samples.
    run_period(2, -1, '0, '0, 1'b1);
    run_period(0, -1, '0, '0, 1'b1);
    run_period(0, -1, '0, '0, 1'b1);
    run_period(0, -1, '0, '0, 1'b0);
    run_period(1, -1, '0, '0, 1'b0);

    // Asynchronous reset in the middle of WAIT_ACK.
    lat = 3;
    repeat (2) @(negedge Clk);
    check("pre_reset_req", mem.Mem_Req, 1);
    Reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge Clk);
    Address = 20'h00800; End_Address = 20'h00804;
    apply_note(20'h00800, 20'h00804);
    m_inv = 1'b0; m_ovr = 1'b0; m_sample = '0;
    Reset_n = 1'b1;
    wait_cyc(CLK_DIV - 1);

    // Randomized notes, latencies, note_start offsets and invalid_note.
    for (int i = 0; i < 30; i++) begin
      int            l, r, ns;
      logic [AW-1:0] na;
      logic          ni;
      l  = $urandom_range(0, 5);
      r  = $urandom_range(0, 9);
      ns = -1;
      if (r == 0)                ns = CLK_DIV - 1;
      else if (r == 1 && l >= 1) ns = $urandom_range(0, l);
      else if (r == 2)           ns = $urandom_range(0, CLK_DIV - 2);
      na = AW'($urandom_range(0, 32'h000FFFF0));
      ni = ($urandom_range(0, 6) == 0);
      run_period(l, ns, na, na + AW'($urandom_range(0, 4)), ni);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
